// File: rtl/dma_stream_gen.sv
// AXI-Stream pattern source for the DMA S2MM channel: N packets of L bytes, byte k of packet p = p+k.
// Define DMA_GEN_IFG_EN to insert IFG_CYCLES idle cycles between packets.
module dma_stream_gen #(
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned IFG_CYCLES     = 4
) (
    input  logic                        axi_clk,
    input  logic                        axi_rst,
    input  logic                        start,
    input  logic [15:0]                 pkt_bytes,
    input  logic [15:0]                 pkt_count,
    output logic                        busy,
    output logic                        done,
    output logic [15:0]                 pkt_sent,
    input  logic                        s_axis_s2mm_tready,
    output logic [AXI_DATA_WIDTH-1:0]   s_axis_s2mm_tdata,
    output logic [AXI_DATA_WIDTH/8-1:0] s_axis_s2mm_tkeep,
    output logic                        s_axis_s2mm_tvalid,
    output logic                        s_axis_s2mm_tlast
);

    localparam int unsigned BE_WIDTH = AXI_DATA_WIDTH / 8;
    localparam logic [15:0] BeStep   = 16'(BE_WIDTH);

    if (AXI_DATA_WIDTH < 16 || (AXI_DATA_WIDTH % 8) != 0 || IFG_CYCLES < 1 || IFG_CYCLES > 255)
    begin : g_param_check
        $error("dma_stream_gen: parameter out of range");
    end

`ifdef DMA_GEN_IFG_EN
    typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;
    logic [7:0] gap_q, gap_d;
`else
    typedef enum logic [1:0] {StIdle, StSend} state_e;
`endif

    state_e                    state_q, state_d;
    logic [15:0]               bytes_q, bytes_d, count_q, count_d;
    logic [15:0]               off_q, off_d, sent_q, sent_d;
    logic [AXI_DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [BE_WIDTH-1:0]       tkeep_q, tkeep_d;
    logic                      tvalid_q, tvalid_d, tlast_q, tlast_d;
    logic                      done_q, done_d, busy_q, busy_d;

    // Descriptor of the beat that would be presented next, and its contents.
    logic [15:0]               nb_pkt, nb_off, nb_bytes;
    logic [16:0]               nb_rem;
    logic [AXI_DATA_WIDTH-1:0] nb_data;
    logic [BE_WIDTH-1:0]       nb_keep;
    logic                      nb_last;

    always_comb begin
        nb_pkt   = sent_q;
        nb_off   = off_q + BeStep;
        nb_bytes = bytes_q;
        if (state_q == StIdle) begin
            nb_pkt   = '0;
            nb_off   = '0;
            nb_bytes = pkt_bytes;
        end else if (state_q == StSend && tlast_q) begin
            nb_pkt = sent_q + 16'd1;
            nb_off = '0;
        end
`ifdef DMA_GEN_IFG_EN
        else if (state_q == StGap) begin
            nb_off = '0;
        end
`endif
    end

    always_comb begin
        nb_rem  = {1'b0, nb_bytes} - {1'b0, nb_off};
        nb_last = nb_rem <= 17'(BE_WIDTH);
        nb_data = '0;
        nb_keep = '0;
        for (int unsigned i = 0; i < BE_WIDTH; i++) begin
            if (nb_rem > 17'(i)) begin
                nb_keep[i]        = 1'b1;
                nb_data[8*i +: 8] = nb_pkt[7:0] + nb_off[7:0] + 8'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        bytes_d  = bytes_q;
        count_d  = count_q;
        off_d    = off_q;
        sent_d   = sent_q;
        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        done_d   = 1'b0;
`ifdef DMA_GEN_IFG_EN
        gap_d    = gap_q;
`endif
        unique case (state_q)
            StIdle: begin
                // A start coinciding with the done pulse is dropped.
                if (start && !done_q) begin
                    bytes_d = pkt_bytes;
                    count_d = pkt_count;
                    sent_d  = '0;
                    if (pkt_bytes == '0 || pkt_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = StSend;
                        tvalid_d = 1'b1;
                        tdata_d  = nb_data;
                        tkeep_d  = nb_keep;
                        tlast_d  = nb_last;
                        off_d    = nb_off;
                    end
                end
            end
            StSend: begin
                if (tvalid_q && s_axis_s2mm_tready) begin
                    if (tlast_q) begin
                        sent_d = sent_q + 16'd1;
                    end
                    if (tlast_q && sent_d == count_q) begin
                        state_d  = StIdle;
                        tvalid_d = 1'b0;
                        tdata_d  = '0;
                        tkeep_d  = '0;
                        tlast_d  = 1'b0;
                        done_d   = 1'b1;
                    end
`ifdef DMA_GEN_IFG_EN
                    else if (tlast_q) begin
                        state_d  = StGap;
                        tvalid_d = 1'b0;
                        tdata_d  = '0;
                        tkeep_d  = '0;
                        tlast_d  = 1'b0;
                        gap_d    = 8'(IFG_CYCLES - 1);
                    end
`endif
                    else begin
                        tdata_d = nb_data;
                        tkeep_d = nb_keep;
                        tlast_d = nb_last;
                        off_d   = nb_off;
                    end
                end
            end
`ifdef DMA_GEN_IFG_EN
            StGap: begin
                if (gap_q == '0) begin
                    state_d  = StSend;
                    tvalid_d = 1'b1;
                    tdata_d  = nb_data;
                    tkeep_d  = nb_keep;
                    tlast_d  = nb_last;
                    off_d    = nb_off;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
        busy_d = state_d != StIdle;
    end

    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            state_q  <= StIdle;
            bytes_q  <= '0;
            count_q  <= '0;
            off_q    <= '0;
            sent_q   <= '0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef DMA_GEN_IFG_EN
            gap_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            bytes_q  <= bytes_d;
            count_q  <= count_d;
            off_q    <= off_d;
            sent_q   <= sent_d;
            tdata_q  <= tdata_d;
            tkeep_q  <= tkeep_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
`ifdef DMA_GEN_IFG_EN
            gap_q    <= gap_d;
`endif
        end
    end

    assign busy               = busy_q;
    assign done               = done_q;
    assign pkt_sent           = sent_q;
    assign s_axis_s2mm_tdata  = tdata_q;
    assign s_axis_s2mm_tkeep  = tkeep_q;
    assign s_axis_s2mm_tvalid = tvalid_q;
    assign s_axis_s2mm_tlast  = tlast_q;

endmodule
